// File: rtl/shot_ctl.sv
// shot_ctl: mouse-trigger shot controller with a finite magazine, a
// valid/ready shot record, frame-based cooldown and one shot per press.
module shot_ctl #(
  parameter int MAG_SIZE        = 3,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        mouse_left_in,
  input  logic        frame_tick,
  input  logic        reload_in,
  input  logic        shot_ready_in,
  output logic        shot_valid_out,
  output logic [11:0] shot_xpos_out,
  output logic [11:0] shot_ypos_out,
  output logic [2:0]  ammo_out,
  output logic        dry_fire_out
);

  typedef enum logic [1:0] {IDLE, SHOT, COOLDOWN, WAIT_RELEASE} state_t;

  localparam logic [2:0] MAG = 3'(MAG_SIZE);
  localparam logic [7:0] CD  = 8'(COOLDOWN_FRAMES);

  state_t      state_q, state_d;
  logic [2:0]  ammo_q, ammo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        dry_q, dry_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;

  // Next-state and next-output logic; all outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    ammo_d  = ammo_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dry_d   = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        // Reload has priority over a trigger arriving in the same cycle.
        if (reload_in) begin
          ammo_d = MAG;
        end else if (mouse_left_in) begin
          if (ammo_q != 3'd0) begin
            x_d     = xpos_in;
            y_d     = ypos_in;
            valid_d = 1'b1;
            state_d = SHOT;
          end else begin
            dry_d   = 1'b1;
            state_d = WAIT_RELEASE;
          end
        end
      end
      SHOT: begin
        // Ammo is only consumed once the consumer has taken the record.
        if (valid_q && shot_ready_in) begin
          valid_d = 1'b0;
          if (ammo_q != 3'd0) ammo_d = ammo_q - 3'd1;
          if (CD == 8'd0) begin
            state_d = WAIT_RELEASE;
          end else begin
            cnt_d   = CD;
            state_d = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        // Leave on the tick that brings the counter to zero; never wrap.
        if (cnt_q == 8'd0) begin
          state_d = WAIT_RELEASE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!mouse_left_in) state_d = IDLE;
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  // State and output registers; reset parks in WAIT_RELEASE so a held
  // button cannot fire until it is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_RELEASE;
      ammo_q  <= MAG;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      dry_q   <= 1'b0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
    end else begin
      state_q <= state_d;
      ammo_q  <= ammo_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dry_q   <= dry_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign shot_valid_out = valid_q;
  assign shot_xpos_out  = x_q;
  assign shot_ypos_out  = y_q;
  assign ammo_out       = ammo_q;
  assign dry_fire_out   = dry_q;

endmodule

// File: tb/tb_shot_ctl.sv
// Bench for shot_ctl: two configurations driven by shared stimulus, each
// checked every cycle against a behavioural model, plus directed literals.
module tb_shot_ctl;

  logic        clk = 1'b0;
  logic        rst, mouse, tick, reload, ready;
  logic [11:0] xpos, ypos;

  logic        a_valid, b_valid, a_dry, b_dry;
  logic [11:0] a_x, a_y, b_x, b_y;
  logic [2:0]  a_ammo, b_ammo;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shot_ctl #(.MAG_SIZE(3), .COOLDOWN_FRAMES(10)) dut_a (
    .clk(clk), .rst(rst), .xpos_in(xpos), .ypos_in(ypos),
    .mouse_left_in(mouse), .frame_tick(tick), .reload_in(reload),
    .shot_ready_in(ready), .shot_valid_out(a_valid), .shot_xpos_out(a_x),
    .shot_ypos_out(a_y), .ammo_out(a_ammo), .dry_fire_out(a_dry));

  shot_ctl #(.MAG_SIZE(2), .COOLDOWN_FRAMES(0)) dut_b (
    .clk(clk), .rst(rst), .xpos_in(xpos), .ypos_in(ypos),
    .mouse_left_in(mouse), .frame_tick(tick), .reload_in(reload),
    .shot_ready_in(ready), .shot_valid_out(b_valid), .shot_xpos_out(b_x),
    .shot_ypos_out(b_y), .ammo_out(b_ammo), .dry_fire_out(b_dry));

  // Model: a pending record, frames left to cool, and whether the trigger
  // must first be released before it can act again.
  typedef struct {
    bit          pend;
    int          cool;
    bit          need_rel;
    int          ammo;
    logic [11:0] x, y;
    bit          dry;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int mag, int cd);
    if (rst) begin
      m.pend = 0; m.cool = 0; m.need_rel = 1; m.ammo = mag;
      m.x = 0; m.y = 0; m.dry = 0;
      return m;
    end
    m.dry = 0;
    if (m.pend) begin
      if (ready) begin m.pend = 0; m.ammo = m.ammo - 1; m.cool = cd; end
    end else if (m.cool > 0) begin
      if (tick) m.cool = m.cool - 1;
    end else if (m.need_rel) begin
      if (!mouse) m.need_rel = 0;
    end else if (reload) begin
      m.ammo = mag;
    end else if (mouse) begin
      m.need_rel = 1;
      if (m.ammo > 0) begin m.pend = 1; m.x = xpos; m.y = ypos; end
      else m.dry = 1;
    end
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    ma = step(ma, 3, 10);
    mb = step(mb, 2, 0);
  end

  // Compare process: outputs are registered, so checking at the falling
  // edge sees the state settled by the preceding rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", 32'(a_valid), 32'(ma.pend));
      chk("a_x",     32'(a_x),     32'(ma.x));
      chk("a_y",     32'(a_y),     32'(ma.y));
      chk("a_ammo",  32'(a_ammo),  32'(ma.ammo));
      chk("a_dry",   32'(a_dry),   32'(ma.dry));
      chk("b_valid", 32'(b_valid), 32'(mb.pend));
      chk("b_x",     32'(b_x),     32'(mb.x));
      chk("b_y",     32'(b_y),     32'(mb.y));
      chk("b_ammo",  32'(b_ammo),  32'(mb.ammo));
      chk("b_dry",   32'(b_dry),   32'(mb.dry));
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  // One complete shot from IDLE, through cooldown, back to IDLE.
  task automatic shoot(logic [11:0] x, logic [11:0] y);
    mouse = 1; xpos = x; ypos = y; ready = 1;
    nx(); nx();
    mouse = 0; ready = 0;
    repeat (10) begin tick = 1; nx(); tick = 0; nx(); end
    nx(); nx();
  endtask

  initial begin
    rst = 1; mouse = 0; tick = 0; reload = 0; ready = 0; xpos = 0; ypos = 0;
    nx();
    chk_en = 1;
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_ammo",  32'(a_ammo), 3);
    chk("rst_dry",   32'(a_dry), 0);
    chk("rst_x",     32'(a_x), 0);
    rst = 0;
    nx();

    // Trigger with consumer stalled while the mouse moves.
    mouse = 1; xpos = 512; ypos = 384;
    nx();
    chk("lat_valid", 32'(a_valid), 1);
    chk("lat_x", 32'(a_x), 512);
    chk("lat_y", 32'(a_y), 384);
    xpos = 100; ypos = 50;
    repeat (4) begin
      nx();
      chk("hold_valid", 32'(a_valid), 1);
      chk("hold_x", 32'(a_x), 512);
    end
    ready = 1;
    nx();
    chk("hs_valid", 32'(a_valid), 0);
    chk("hs_ammo", 32'(a_ammo), 2);
    chk("hs_x", 32'(a_x), 512);

    // Button held through three cooldown periods: still one shot.
    repeat (30) begin tick = 1; nx(); tick = 0; nx(); end
    chk("held_ammo", 32'(a_ammo), 2);
    chk("held_valid", 32'(a_valid), 0);
    mouse = 0; ready = 0;
    nx(); nx();

    shoot(12'd7, 12'd9);
    chk("ammo1", 32'(a_ammo), 1);
    shoot(12'd1, 12'd2);
    chk("ammo0", 32'(a_ammo), 0);

    // Empty magazine: dry fire pulse only.
    mouse = 1;
    nx();
    chk("dry_pulse", 32'(a_dry), 1);
    chk("dry_novalid", 32'(a_valid), 0);
    nx();
    chk("dry_end", 32'(a_dry), 0);
    mouse = 0;
    nx(); nx();
    reload = 1;
    nx();
    reload = 0;
    chk("reload_ammo", 32'(a_ammo), 3);

    // Reload and trigger together; reload during cooldown.
    shoot(12'd3, 12'd4);
    reload = 1; mouse = 1;
    nx();
    chk("rl_press_ammo", 32'(a_ammo), 3);
    chk("rl_press_valid", 32'(a_valid), 0);
    chk("rl_press_dry", 32'(a_dry), 0);
    reload = 0; mouse = 0;
    nx();
    mouse = 1; ready = 1;
    nx(); nx();
    mouse = 0; ready = 0; reload = 1;
    nx();
    reload = 0;
    chk("cd_reload_ammo", 32'(a_ammo), 2);
    repeat (10) begin tick = 1; nx(); tick = 0; nx(); end
    nx(); nx();

    // Reset during SHOT with button held.
    mouse = 1; ready = 0;
    nx();
    chk("pre_rst_valid", 32'(a_valid), 1);
    rst = 1;
    nx();
    rst = 0;
    chk("shot_rst_valid", 32'(a_valid), 0);
    chk("shot_rst_ammo", 32'(a_ammo), 3);
    repeat (4) nx();
    chk("held_rst_valid", 32'(a_valid), 0);
    mouse = 0;
    nx(); nx();
    mouse = 1;
    nx();
    chk("repress_valid", 32'(a_valid), 1);
    ready = 1;
    nx();
    chk("repress_ammo", 32'(a_ammo), 2);
    mouse = 0; ready = 0;

    // Randomised traffic against the model.
    repeat (3000) begin
      rst    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) mouse = ~mouse;
      tick   = ($urandom_range(0, 3) == 0);
      reload = ($urandom_range(0, 19) == 0);
      ready  = ($urandom_range(0, 1) == 0);
      xpos   = 12'($urandom);
      ypos   = 12'($urandom);
      nx();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
